// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: state encodings and default widths.
package counter_seq_pkg;

  localparam int DEF_W = 4;
  localparam int DEF_R = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_seq_core.sv
// Count datapath: owns q, wraps at the programmed terminal value, exposes the
// terminal-compare flag to the sequencer.
module seq_cnt_core
  import counter_seq_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         ck,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic [W-1:0] q,
  output logic         eq
);

  assign eq = (q == lim);

  // Clear wins over enable; an enabled count at the terminal value wraps to 0.
  always_ff @(posedge ck) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= eq ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_seq.sv
// Run-control sequencer for the counter datapath: start/stop/pause, latched
// terminal and repeat counts, tick on every wrap and done after the final pass.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start; q held at 0
//   ST_RUN  | counting 0..lim, one increment per cycle
//   ST_HOLD | paused; q frozen until pause drops
//   ST_DONE | single cycle after the last pass; done pulses, then IDLE
module counter_seq
  import counter_seq_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int R = DEF_R
) (
  input  logic         ck,
  input  logic         res,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic [W-1:0] limit,
  input  logic [R-1:0] rep,
  output logic [W-1:0] q,
  output logic         busy,
  output logic         tick,
  output logic         done
);

  state_t       state;
  logic [W-1:0] lim;
  logic [R-1:0] rp;
  logic [R-1:0] pc;
  logic         eq;
  logic         cnt_clr;
  logic         cnt_en;
  logic         last_pass;

  // The datapath is cleared on reset, stop, and when a run is launched, so a
  // new run always begins at 0 whatever state the previous one left behind.
  assign cnt_clr = res | stop | ((state == ST_IDLE) & start);
  assign cnt_en  = (state == ST_RUN) & ~pause;

  // pc counts completed passes; widen by one bit so pc+1 cannot alias rp.
  assign last_pass = (rp != '0) && (({1'b0, pc} + 1'b1) == {1'b0, rp});

  seq_cnt_core #(.W(W)) u_core (
    .ck  (ck),
    .clr (cnt_clr),
    .en  (cnt_en),
    .lim (lim),
    .q   (q),
    .eq  (eq)
  );

  // Sequencer FSM with registered status outputs; priority res > stop > rest.
  always_ff @(posedge ck) begin
    if (res) begin
      state <= ST_IDLE;
      lim   <= '0;
      rp    <= '0;
      pc    <= '0;
      busy  <= 1'b0;
      tick  <= 1'b0;
      done  <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              lim   <= limit;
              rp    <= rep;
              pc    <= '0;
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
          ST_RUN: begin
            if (pause) begin
              state <= ST_HOLD;
            end else if (eq) begin
              tick <= 1'b1;
              if (last_pass) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else if (pc != {R{1'b1}}) begin
                // Free-running mode (rp=0) lets pc saturate rather than wrap.
                pc <= pc + 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (!pause) begin
              state <= ST_RUN;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
